// File: rtl/cpu_csr_pkg.sv
// Shared CSR address map, counter bit indices and mask helper for the counter unit.
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package cpu_csr_pkg;

  // User read-only views: low half at C00+N, high half at C80+N
  localparam logic [11:0] CSR_CYCLE         = 12'hC00;
  localparam logic [11:0] CSR_TIME          = 12'hC01;
  localparam logic [11:0] CSR_INSTRET       = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH        = 12'hC80;

  // Machine writable views: low half at B00+N, high half at B80+N
  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;

  localparam logic [11:0] CSR_SCOUNTEREN    = 12'h106;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

  // Ignoring bit 7 (low/high) and bits 4:0 (counter index) of a counter address
  localparam logic [11:0] CSR_CNT_MASK      = 12'hF60;
  // Ignoring bits 4:0 of the 0x320 block
  localparam logic [11:0] CSR_BLK_MASK      = 12'hFE0;

  // Bit positions shared by mcountinhibit, scounteren and the counter index
  localparam int IDX_CY  = 0;
  localparam int IDX_TM  = 1;
  localparam int IDX_IR  = 2;
  localparam int IDX_HPM = 3;

  localparam int MAX_HPM = 29;

  // Writable bits of mcountinhibit: cycle, instret and the implemented HPMs
  function automatic logic [31:0] cnt_mask(input int hpm);
    logic [31:0] m;
    m = 32'h0;
    m[IDX_CY] = 1'b1;
    m[IDX_IR] = 1'b1;
    for (int i = 0; i < hpm; i++) begin
      m[IDX_HPM + i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/cpu_csr_counter.sv
// One W-bit counter with independent low/high half write enables.
// Latency: write or increment visible one cycle after the sampling clk edge.
// Backpressure: none; a write in the same cycle drops that cycle's increment.
module cpu_csr_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  input  logic         i_wr_lo,
  input  logic         i_wr_hi,
  input  logic [31:0]  i_wdat,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Half writes take priority over the increment and preserve the other half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_wr_lo) begin
      r_cnt[31:0] <= i_wdat;
    end else if (i_wr_hi) begin
      r_cnt[W-1:32] <= i_wdat[W-33:0];
    end else if (i_inc) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cpu_csr_counters.sv
// Counter/timer CSR unit: cycle, time, instret and HPM counters; build HPMs with CPU_CSR_HPM_EN.
// Latency: reads combinational from addr; writes and counts visible the cycle after the clk edge.
// Backpressure: none; illegal accesses read 0 and suppress the write.
module cpu_csr_counters
  import cpu_csr_pkg::*;
#(
  parameter int HPM_COUNT   = 4,
  parameter int CNT_WIDTH   = 64,
  parameter int EVENT_COUNT = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [11:0]            addr,
  input  logic [31:0]            data_in,
  input  logic                   wr,
  input  logic                   priv_user,
  output logic [31:0]            data_out,
  output logic                   hit,
  output logic                   illegal,
  input  logic                   inst_tick,
  input  logic                   timer_tick,
  input  logic [EVENT_COUNT-1:0] events
);

`ifdef CPU_CSR_HPM_EN
  localparam int HPM_EFF = HPM_COUNT;
`else
  localparam int HPM_EFF = 0;
`endif
  localparam int          NCNT      = IDX_HPM + HPM_EFF;
  localparam logic [31:0] INH_MASK  = cnt_mask(HPM_EFF);
  localparam logic [31:0] SCEN_MASK = INH_MASK | (32'h1 << IDX_TM);
  // Address range is decoded from HPM_COUNT even when HPMs are not built
  localparam logic [5:0]  IDX_END   = 6'(IDX_HPM + HPM_COUNT);

  logic [4:0]           w_idx;
  logic                 w_idx_ok;
  logic                 w_c_hit, w_b_hit, w_inh_hit, w_evt_hit, w_scen_hit;
  logic                 w_illegal, w_wr_ok, w_wr_lo_en, w_wr_hi_en;
  logic [31:0]          w_rdata;
  logic [63:0]          w_ext;
  logic [CNT_WIDTH-1:0] w_cnt [32];
  logic [4:0]           w_evt_sel [32];
  logic [31:0]          r_inh, r_scen;
  logic                 r_inst_prev, r_timer_prev;

  // Address decode
  assign w_idx      = addr[4:0];
  assign w_idx_ok   = ({1'b0, w_idx} < IDX_END);
  assign w_c_hit    = ((addr & CSR_CNT_MASK) == CSR_CYCLE) && w_idx_ok;
  assign w_b_hit    = ((addr & CSR_CNT_MASK) == CSR_MCYCLE) && w_idx_ok
                      && (w_idx != 5'(IDX_TM));
  assign w_inh_hit  = (addr == CSR_MCOUNTINHIBIT);
  assign w_evt_hit  = ((addr & CSR_BLK_MASK) == CSR_MCOUNTINHIBIT)
                      && (w_idx >= 5'(IDX_HPM)) && w_idx_ok;
  assign w_scen_hit = (addr == CSR_SCOUNTEREN);

  assign hit = w_c_hit | w_b_hit | w_inh_hit | w_evt_hit | w_scen_hit;

  // C-range is never writable; user mode only reaches C-range counters enabled in scounteren
  assign w_illegal = (wr & w_c_hit)
                   | (priv_user & (w_b_hit | w_inh_hit | w_evt_hit | w_scen_hit))
                   | (priv_user & w_c_hit & ~r_scen[w_idx]);
  assign illegal    = w_illegal;
  assign w_wr_ok    = wr & ~w_illegal;
  assign w_wr_lo_en = w_wr_ok & w_b_hit & ~addr[7];
  assign w_wr_hi_en = w_wr_ok & w_b_hit &  addr[7];

  // Read mux; high halves return bits above 31 zero-extended
  always_comb begin
    w_rdata = 32'h0;
    w_ext   = 64'(w_cnt[w_idx]);
    if (w_c_hit || w_b_hit) begin
      w_rdata = addr[7] ? w_ext[63:32] : w_ext[31:0];
    end else if (w_inh_hit) begin
      w_rdata = r_inh;
    end else if (w_scen_hit) begin
      w_rdata = r_scen;
    end else if (w_evt_hit) begin
      w_rdata = 32'(w_evt_sel[w_idx]);
    end
  end

  assign data_out = w_illegal ? 32'h0 : w_rdata;

  // Control registers keep only their implemented bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inh  <= '0;
      r_scen <= '0;
    end else if (w_wr_ok && w_inh_hit) begin
      r_inh  <= data_in & INH_MASK;
    end else if (w_wr_ok && w_scen_hit) begin
      r_scen <= data_in & SCEN_MASK;
    end
  end

  // Previous samples for rising-edge detection of the tick levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inst_prev  <= 1'b0;
      r_timer_prev <= 1'b0;
    end else begin
      r_inst_prev  <= inst_tick;
      r_timer_prev <= timer_tick;
    end
  end

  cpu_csr_counter #(.W(CNT_WIDTH)) u_cycle (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (~r_inh[IDX_CY]),
    .i_wr_lo (w_wr_lo_en && (w_idx == 5'(IDX_CY))),
    .i_wr_hi (w_wr_hi_en && (w_idx == 5'(IDX_CY))),
    .i_wdat  (data_in),
    .o_cnt   (w_cnt[IDX_CY])
  );

  // time has no machine write view
  cpu_csr_counter #(.W(CNT_WIDTH)) u_time (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (timer_tick & ~r_timer_prev),
    .i_wr_lo (1'b0),
    .i_wr_hi (1'b0),
    .i_wdat  (data_in),
    .o_cnt   (w_cnt[IDX_TM])
  );

  cpu_csr_counter #(.W(CNT_WIDTH)) u_instret (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (inst_tick & ~r_inst_prev & ~r_inh[IDX_IR]),
    .i_wr_lo (w_wr_lo_en && (w_idx == 5'(IDX_IR))),
    .i_wr_hi (w_wr_hi_en && (w_idx == 5'(IDX_IR))),
    .i_wdat  (data_in),
    .o_cnt   (w_cnt[IDX_IR])
  );

  assign w_evt_sel[IDX_CY] = '0;
  assign w_evt_sel[IDX_TM] = '0;
  assign w_evt_sel[IDX_IR] = '0;

`ifdef CPU_CSR_HPM_EN
  logic [EVENT_COUNT-1:0] r_evt_prev;
  logic [31:0]            w_evt_vec;

  // Previous samples for rising-edge detection of the event levels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_prev <= '0;
    end else begin
      r_evt_prev <= events;
    end
  end

  // Bit k holds the edge of events[k-1]; bit 0 and unused selectors stay 0
  assign w_evt_vec = 32'({events & ~r_evt_prev, 1'b0});

  for (genvar n = IDX_HPM; n < 32; n++) begin : g_hpm
    if (n < NCNT) begin : g_impl
      logic [4:0] r_sel;

      // mhpmevent selector, 5 bits stored
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sel <= '0;
        end else if (w_wr_ok && w_evt_hit && (w_idx == 5'(n))) begin
          r_sel <= data_in[4:0];
        end
      end

      assign w_evt_sel[n] = r_sel;

      cpu_csr_counter #(.W(CNT_WIDTH)) u_hpm (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_evt_vec[r_sel] & ~r_inh[n]),
        .i_wr_lo (w_wr_lo_en && (w_idx == 5'(n))),
        .i_wr_hi (w_wr_hi_en && (w_idx == 5'(n))),
        .i_wdat  (data_in),
        .o_cnt   (w_cnt[n])
      );
    end else begin : g_none
      assign w_cnt[n]     = '0;
      assign w_evt_sel[n] = '0;
    end
  end
`else
  logic w_unused_events;
  assign w_unused_events = ^events;

  for (genvar n = IDX_HPM; n < 32; n++) begin : g_hpm
    assign w_cnt[n]     = '0;
    assign w_evt_sel[n] = '0;
  end
`endif

endmodule

// File: tb/tb_cpu_csr_counters.sv
// Directed bench for cpu_csr_counters with CNT_WIDTH = 40 and HPM_COUNT = 4.
// Latency: reads sampled #1 after setting addr; writes checked after their clk edge.
// Backpressure: n/a.
module tb_cpu_csr_counters;

  logic        clk;
  logic        rst_n;
  logic [11:0] addr;
  logic [31:0] data_in;
  logic        wr;
  logic        priv_user;
  logic [31:0] data_out;
  logic        hit;
  logic        illegal;
  logic        inst_tick;
  logic        timer_tick;
  logic [7:0]  events;

  int checks = 0;
  int errors = 0;

`ifdef CPU_CSR_HPM_EN
  localparam logic [31:0] EXP_INH  = 32'h0000_007D;
  localparam logic [31:0] EXP_SCEN = 32'h0000_007F;
`else
  localparam logic [31:0] EXP_INH  = 32'h0000_0005;
  localparam logic [31:0] EXP_SCEN = 32'h0000_0007;
`endif

  cpu_csr_counters #(
    .HPM_COUNT   (4),
    .CNT_WIDTH   (40),
    .EVENT_COUNT (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .data_in    (data_in),
    .wr         (wr),
    .priv_user  (priv_user),
    .data_out   (data_out),
    .hit        (hit),
    .illegal    (illegal),
    .inst_tick  (inst_tick),
    .timer_tick (timer_tick),
    .events     (events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic rd(input logic [11:0] a);
    addr = a;
    #1;
  endtask

  task automatic wr_csr(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    addr    = a;
    data_in = d;
    wr      = 1'b1;
    @(posedge clk);
    #1;
    wr      = 1'b0;
  endtask

  task automatic pulse_events(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      events = m;
      @(negedge clk);
      events = 8'h0;
    end
    #1;
  endtask

  task automatic test_reset;
    logic [11:0] a_tab [15];
    logic        h_tab [15];
    a_tab = '{12'hC00, 12'hC01, 12'hC02, 12'hC03, 12'hC06, 12'hC80, 12'hC82,
              12'hB00, 12'hB80, 12'hB02, 12'h320, 12'h323, 12'h106,
              12'hB01, 12'h7C0};
    h_tab = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
              1'b0, 1'b0};
    #3;
    for (int i = 0; i < 15; i++) begin
      rd(a_tab[i]);
      checks++;
      if (data_out !== 32'h0 || illegal !== 1'b0 || hit !== h_tab[i]) begin
        errors++;
        $display("FAIL reset_read addr=%h: data=%h ill=%b hit=%b, expected data=0 ill=0 hit=%b",
                 a_tab[i], data_out, illegal, hit, h_tab[i]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    rd(12'hC00);
    checks++;
    if (data_out !== 32'd10) begin
      errors++;
      $display("FAIL cycle_after_10: got %0d expected 10", data_out);
    end
    rd(12'hC01);
    checks++;
    if (data_out !== 32'd0) begin
      errors++;
      $display("FAIL time_idle: got %0d expected 0", data_out);
    end
    rd(12'hC02);
    checks++;
    if (data_out !== 32'd0) begin
      errors++;
      $display("FAIL instret_idle: got %0d expected 0", data_out);
    end
  endtask

  task automatic test_instret;
    @(negedge clk);
    inst_tick = 1'b1;
    repeat (5) @(negedge clk);
    inst_tick = 1'b0;
    rd(12'hC02);
    checks++;
    if (data_out !== 32'd1) begin
      errors++;
      $display("FAIL instret_level_once: got %0d expected 1", data_out);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      inst_tick = 1'b1;
      @(negedge clk);
      inst_tick = 1'b0;
    end
    rd(12'hC02);
    checks++;
    if (data_out !== 32'd4) begin
      errors++;
      $display("FAIL instret_pulses: got %0d expected 4", data_out);
    end
  endtask

  task automatic test_wrap_and_write;
    // high write truncated to 8 bits, then low write sets all ones
    wr_csr(12'hB80, 32'h1234_56FF);
    wr_csr(12'hB00, 32'hFFFF_FFFF);
    rd(12'hC00);
    checks++;
    if (data_out !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL cycle_lo_written: got %h expected ffffffff", data_out);
    end
    rd(12'hC80);
    checks++;
    if (data_out !== 32'h0000_00FF) begin
      errors++;
      $display("FAIL cycle_hi_truncated: got %h expected 000000ff", data_out);
    end
    @(posedge clk);
    #1;
    rd(12'hC00);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL cycle_wrap_lo: got %h expected 00000000", data_out);
    end
    rd(12'hC80);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL cycle_wrap_hi: got %h expected 00000000", data_out);
    end
    // low write on an incrementing cycle keeps exactly the written value and the high half
    wr_csr(12'hB80, 32'hABCD_EF5A);
    wr_csr(12'hB00, 32'h1234_5678);
    rd(12'hB00);
    checks++;
    if (data_out !== 32'h1234_5678) begin
      errors++;
      $display("FAIL write_beats_inc: got %h expected 12345678", data_out);
    end
    rd(12'hC80);
    checks++;
    if (data_out !== 32'h0000_005A) begin
      errors++;
      $display("FAIL hi_preserved: got %h expected 0000005a", data_out);
    end
    // minstret high write keeps the low half
    wr_csr(12'hB82, 32'h0000_0001);
    rd(12'hC82);
    checks++;
    if (data_out !== 32'h1) begin
      errors++;
      $display("FAIL instret_hi: got %h expected 00000001", data_out);
    end
    rd(12'hC02);
    checks++;
    if (data_out !== 32'h4) begin
      errors++;
      $display("FAIL instret_lo_kept: got %h expected 00000004", data_out);
    end
  endtask

  task automatic test_hpm;
    wr_csr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320);
    checks++;
    if (data_out !== EXP_INH) begin
      errors++;
      $display("FAIL inhibit_mask: got %h expected %h", data_out, EXP_INH);
    end
    wr_csr(12'h320, 32'h0);
`ifdef CPU_CSR_HPM_EN
    wr_csr(12'h323, 32'hFFFF_FFE2);
    rd(12'h323);
    checks++;
    if (data_out !== 32'h2) begin
      errors++;
      $display("FAIL mhpmevent3_5bit: got %h expected 00000002", data_out);
    end
    pulse_events(8'h01, 1);
    rd(12'hC03);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL hpm_unselected: got %0d expected 0", data_out);
    end
    pulse_events(8'h02, 7);
    rd(12'hC03);
    checks++;
    if (data_out !== 32'd7) begin
      errors++;
      $display("FAIL hpm3_count: got %0d expected 7", data_out);
    end
    wr_csr(12'h320, 32'h0000_0008);
    pulse_events(8'h02, 3);
    rd(12'hB03);
    checks++;
    if (data_out !== 32'd7) begin
      errors++;
      $display("FAIL hpm3_inhibited: got %0d expected 7", data_out);
    end
    wr_csr(12'h320, 32'h0);
    wr_csr(12'h323, 32'h0);
    pulse_events(8'h02, 3);
    rd(12'hC03);
    checks++;
    if (data_out !== 32'd7) begin
      errors++;
      $display("FAIL hpm3_no_event: got %0d expected 7", data_out);
    end
`else
    wr_csr(12'h323, 32'h2);
    wr_csr(12'hB03, 32'h5);
    pulse_events(8'h02, 2);
    rd(12'h323);
    checks++;
    if (data_out !== 32'h0 || hit !== 1'b1) begin
      errors++;
      $display("FAIL mhpmevent3_off: data=%h hit=%b expected data=0 hit=1", data_out, hit);
    end
    rd(12'hC03);
    checks++;
    if (data_out !== 32'h0 || hit !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL hpm3_off: data=%h hit=%b ill=%b expected data=0 hit=1 ill=0",
               data_out, hit, illegal);
    end
`endif
  endtask

  task automatic test_user_access;
    @(negedge clk);
    priv_user = 1'b1;
    rd(12'hC00);
    checks++;
    if (illegal !== 1'b1 || data_out !== 32'h0 || hit !== 1'b1) begin
      errors++;
      $display("FAIL user_c00_gated: ill=%b data=%h hit=%b expected ill=1 data=0 hit=1",
               illegal, data_out, hit);
    end
    rd(12'hB00);
    checks++;
    if (illegal !== 1'b1 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL user_b00: ill=%b data=%h expected ill=1 data=0", illegal, data_out);
    end
    rd(12'h106);
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL user_106: ill=%b expected 1", illegal);
    end
    rd(12'h321);
    checks++;
    if (illegal !== 1'b0 || hit !== 1'b0 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL user_unmapped: ill=%b hit=%b data=%h expected 0 0 0", illegal, hit, data_out);
    end
    priv_user = 1'b0;
    wr_csr(12'h106, 32'hFFFF_FFFF);
    rd(12'h106);
    checks++;
    if (data_out !== EXP_SCEN) begin
      errors++;
      $display("FAIL scen_mask: got %h expected %h", data_out, EXP_SCEN);
    end
    wr_csr(12'h106, 32'h0000_0005);
    priv_user = 1'b1;
    rd(12'hC00);
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL user_c00_enabled: ill=%b expected 0", illegal);
    end
    rd(12'hC02);
    checks++;
    if (illegal !== 1'b0 || data_out !== 32'h4) begin
      errors++;
      $display("FAIL user_instret: ill=%b data=%h expected ill=0 data=4", illegal, data_out);
    end
    rd(12'hC82);
    checks++;
    if (data_out !== 32'h1) begin
      errors++;
      $display("FAIL user_instreth: got %h expected 1", data_out);
    end
    rd(12'hC01);
    checks++;
    if (illegal !== 1'b1 || data_out !== 32'h0) begin
      errors++;
      $display("FAIL user_time_gated: ill=%b data=%h expected ill=1 data=0", illegal, data_out);
    end
    // user write to C-range: flagged and dropped
    @(negedge clk);
    addr    = 12'hC02;
    data_in = 32'h0000_0100;
    wr      = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL user_wr_c02: ill=%b expected 1", illegal);
    end
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd(12'hC02);
    checks++;
    if (data_out !== 32'h4) begin
      errors++;
      $display("FAIL c02_unchanged: got %h expected 4", data_out);
    end
    // machine write to C-range is also illegal
    @(negedge clk);
    priv_user = 1'b0;
    addr      = 12'hC00;
    wr        = 1'b1;
    #1;
    checks++;
    if (illegal !== 1'b1) begin
      errors++;
      $display("FAIL mach_wr_c00: ill=%b expected 1", illegal);
    end
    wr = 1'b0;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    rd(12'hC00);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_cycle: got %h expected 0", data_out);
    end
    rd(12'hC82);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_instreth: got %h expected 0", data_out);
    end
    rd(12'h106);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL areset_scen: got %h expected 0", data_out);
    end
    // write attempted and tick raised while held in reset
    addr       = 12'hB02;
    data_in    = 32'h55;
    wr         = 1'b1;
    timer_tick = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wr    = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(12'hC01);
    checks++;
    if (data_out !== 32'h1) begin
      errors++;
      $display("FAIL tick_high_at_release: got %0d expected 1", data_out);
    end
    rd(12'hC02);
    checks++;
    if (data_out !== 32'h0) begin
      errors++;
      $display("FAIL write_in_reset: got %h expected 0", data_out);
    end
    repeat (3) @(posedge clk);
    #1;
    rd(12'hC01);
    checks++;
    if (data_out !== 32'h1) begin
      errors++;
      $display("FAIL time_held_level: got %0d expected 1", data_out);
    end
    rd(12'hC00);
    checks++;
    if (data_out !== 32'd4) begin
      errors++;
      $display("FAIL cycle_after_release: got %0d expected 4", data_out);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    addr       = 12'h0;
    data_in    = 32'h0;
    wr         = 1'b0;
    priv_user  = 1'b0;
    inst_tick  = 1'b0;
    timer_tick = 1'b0;
    events     = 8'h0;
    test_reset();
    test_instret();
    test_wrap_and_write();
    test_hpm();
    test_user_access();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
